// File: rtl/fifo_rr_drain_if.sv
// Bus bundle for fifo_rr_drain: the read side of the source FIFOs plus the
// valid/ready output stream. The master modport is the scheduler itself.
interface fifo_rr_drain_if #(
    parameter int N_SRC     = 4,
    parameter int DATA_WIDE = 64,
    parameter int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    // Source FIFO side
    logic [N_SRC-1:0]           fifo_empty;
    logic [N_SRC-1:0]           fifo_rd_en;
    logic [N_SRC*DATA_WIDE-1:0] fifo_dout;

    // Output stream side
    logic [DATA_WIDE-1:0]       out_data;
    logic [SRC_W-1:0]           out_src;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;

    // Scheduler view: reads the FIFOs, drives the stream.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_src,
        output out_last,
        output out_valid
    );

    // Environment view: FIFOs and downstream consumer.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_src,
        input  out_last,
        input  out_valid
    );
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin burst drain of N_SRC synchronous FIFOs (1-cycle read latency)
// onto a single registered valid/ready stream. This block is the only reader
// of the FIFOs, so a granted FIFO is never empty when it is read.
module fifo_rr_drain #(
    parameter int N_SRC     = 4,
    parameter int DATA_WIDE = 64,
    parameter int BURST     = 4
) (
    input logic             clk,
    input logic             rst,
    fifo_rr_drain_if.master bus
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    typedef enum logic [1:0] {
        ARB     = 2'd0,  // pick the next non-empty source from ptr onward
        READ    = 2'd1,  // pulse rd_en of the granted FIFO
        CAPTURE = 2'd2,  // FIFO dout is valid, register it
        HOLD    = 2'd3   // present the word until the handshake
    } state_t;

    state_t               state;
    logic [SRC_W-1:0]     grant;
    logic [SRC_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_WIDE-1:0] data_q;
    logic [SRC_W-1:0]     src_q;
    logic                 valid_q;

    logic                 any_ready;
    logic [SRC_W-1:0]     arb_pick;
    logic                 sel_empty;
    logic [DATA_WIDE-1:0] sel_dout;
    logic                 last;
    logic [N_SRC-1:0]     rd_en;

    // (base + off) mod N_SRC for base < N_SRC and off <= N_SRC; the explicit
    // subtraction keeps the wrap correct for non-power-of-2 source counts.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= unsigned'(N_SRC)) begin
            sum = sum - unsigned'(N_SRC);
        end
        return SRC_W'(sum);
    endfunction

    // Bit select by a source index, written as a compare mux so an index
    // wider than the vector never produces an out-of-range select.
    function automatic logic bit_at(input logic [N_SRC-1:0] vec,
                                    input logic [SRC_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx == SRC_W'(i)) begin
                b = vec[i];
            end
        end
        return b;
    endfunction

    // First non-empty source at or after start, walking cyclically. The loop
    // runs from the farthest offset down, so the nearest candidate wins.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [N_SRC-1:0] empty,
                                                 input logic [SRC_W-1:0] start);
        logic [SRC_W-1:0] pick;
        logic [SRC_W-1:0] cand;
        pick = start;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = wrap_add(start, 32'(k));
            if (!bit_at(empty, cand)) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign any_ready = |(~bus.fifo_empty);
    assign arb_pick  = rr_pick(bus.fifo_empty, ptr);
    assign sel_empty = bit_at(bus.fifo_empty, grant);

    // A burst ends on the BURST-th word or as soon as the granted FIFO runs
    // dry; a write landing during HOLD can therefore extend the burst.
    assign last = (state == HOLD) && ((cnt == LAST_CNT) || sel_empty);

    // Mux the granted FIFO's read data for the capture register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_dout = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_dout = bus.fifo_dout[i*DATA_WIDE +: DATA_WIDE];
            end
        end
    end

    // Decode the single rd_en pulse from the READ state; one-hot by construction.
    always_comb begin
        rd_en = '0;
        if (state == READ) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant == SRC_W'(i)) begin
                    rd_en[i] = 1'b1;
                end
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = data_q;
    assign bus.out_src    = src_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last;

    // Scheduler FSM: arbitration, read, capture and hold of each burst word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // A read in flight is simply dropped; the FIFOs reset alongside.
            state   <= ARB;
            grant   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the values from before this edge, independent of statement order.
            case (state)
                ARB: begin
                    if (any_ready) begin
                        grant <= arb_pick;
                        cnt   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    data_q  <= sel_dout;
                    src_q   <= grant;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    // Without a handshake nothing moves and no FIFO is read,
                    // so backpressure can never drop a word.
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (last) begin
                            ptr   <= wrap_add(grant, 32'd1);
                            state <= ARB;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin read scheduler that drains N_SRC external sync FIFOs (1-cycle read latency, registered `dout`) onto one valid/ready output stream. It is the sole reader of those FIFOs and owns their `rd_en` lines. Each grant is a burst of up to BURST words. It sits between per-channel activation/partial-sum FIFOs and the shared downstream consumer.

## Interface
- `N_SRC`, 4: number of source FIFOs (≥1).
- `DATA_WIDE`, 64: word width.
- `BURST`, 4: max words per grant (≥1).
- Derived `SRC_W` = max(1, $clog2(N_SRC)). Derived `CNT_W` = max(1, $clog2(BURST)).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  N_SRC  bit i is the `empty` flag of FIFO i.
- `fifo_rd_en`  out  N_SRC  bit i is the `rd_en` of FIFO i; at most one bit is high.
- `fifo_dout`  in  N_SRC*DATA_WIDE  FIFO i data at `[i*DATA_WIDE +: DATA_WIDE]`.
- `out_data`  out  DATA_WIDE  registered output word.
- `out_src`  out  SRC_W  index of the source FIFO for `out_data`.
- `out_last`  out  1  current word ends its grant.
- `out_valid`  out  1  output word is valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

## Operation
- Registers: `state`, `grant` (SRC_W), `ptr` (SRC_W, RR start), `cnt` (CNT_W), `out_data`, `out_src`, `out_valid`.
- Reset (async, immediate): `state`=ARB, `ptr`=0, `grant`=0, `cnt`=0, `out_data`=0, `out_src`=0, `out_valid`=0. `fifo_rd_en`=0 and `out_last`=0 because both decode from state. A read in flight at reset is discarded. The system resets the FIFOs together with this block.
- FSM states: ARB, READ, CAPTURE, HOLD.
  - **ARB.** Search i = ptr, ptr+1, … (mod N_SRC) for the first i with `!fifo_empty[i]`. If one is found: `grant`<=i, `cnt`<=0, go to READ. Otherwise stay in ARB.
  - **READ.** `fifo_rd_en[grant]`=1 for exactly this cycle. Go to CAPTURE. The granted FIFO cannot be empty here, because no other reader exists.
  - **CAPTURE.** `fifo_dout[grant]` is valid this cycle. Register `out_data`<=that slice, `out_src`<=`grant`, `out_valid`<=1. Go to HOLD.
  - **HOLD.** `out_valid`=1. `out_data` and `out_src` are held stable until the handshake.
    - `out_last` = (`cnt`==BURST-1) || `fifo_empty[grant]`, combinational. It is 0 outside HOLD.
    - On handshake: `out_valid`<=0.
    - If `out_last`: `ptr`<=(`grant`+1) mod N_SRC (N_SRC-1 wraps to 0; when N_SRC is not a power of 2, wrap explicitly), then go to ARB.
    - Otherwise: `cnt`<=`cnt`+1, go to READ.
    - With no handshake: stay in HOLD and issue no reads.
- A write into the granted FIFO during HOLD can clear `fifo_empty[grant]` and so extend the burst, up to the BURST cap. This is intended.
- When N_SRC=1, `ptr` and `grant` stay 0.
- When BURST=1, `out_last` is always 1 in HOLD.

## Timing
- First word: ARB in cycle a, `fifo_rd_en` in a+1, capture in a+2, `out_valid` in a+3.
- Within a burst, with `out_ready`=1: the handshake in cycle h is followed by the next `rd_en` in h+1 and `out_valid` in h+3. Steady state is 1 word per 3 cycles.
- Between grants: handshake with `out_last` in h, ARB in h+1, next `rd_en` in h+2.
- `fifo_empty` is sampled in ARB and HOLD only. `fifo_dout` is sampled in CAPTURE only.
- Backpressure never causes a FIFO read, so no data is dropped.

## Test plan
- **Single source.** FIFO0 holds A,B,C; others empty; BURST=4; `out_ready`=1.
  - Required: A,B,C with `out_src`=0, `out_last` only on C, `rd_en[0]` pulses 3 cycles apart.
  - Required: first `out_valid` 3 cycles after the ARB cycle.
  - Required: `ptr`=1 afterwards.
- **Full round robin.** All 4 FIFOs hold 6 words; BURST=4.
  - Required order: src0×4, src1×4, src2×4, src3×4, then src0×2, src1×2, src2×2, src3×2.
  - Required: `out_last` on the 4th word of each first-round burst and the 2nd word of each second-round burst.
- **Backpressure.** `out_ready`=0 for 5 cycles while in HOLD.
  - Required: `out_data`, `out_src` and `out_valid` stay stable; `fifo_rd_en`=0 throughout.
  - Required: the stream resumes with no loss or duplication.
- **Pointer wrap.** After a grant to src2, `ptr`=3; only src0 and src3 are non-empty.
  - Required: src3 burst first, then src0.
- **Early burst end.** src1 holds 1 word; BURST=4.
  - Required: one word with `out_last`=1, then the grant moves on.
  - Variant: a write to src1 during HOLD extends the burst to 2 words.
- **Reset mid-HOLD.** Assert `rst` asynchronously.
  - Required: `out_valid`, `fifo_rd_en` and `out_last` go to 0 at once.
  - Required: after release, arbitration restarts from src0.
